// File: rtl/rr_arbiter.sv
// Registered round-robin / fixed-priority arbiter with grant tenure and a bounded hold limit.
// One grant per clock at most. The owner keeps its grant while it requests, until MAX_HOLD
// cycles have elapsed. At tenure end the next owner is chosen in the same cycle, so there
// is no idle bubble between back-to-back grants.
module rr_arbiter #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned MAX_HOLD  = 8,
    parameter int unsigned RR_MODE   = 1,
    localparam int unsigned ID_W     = $clog2(NUM_PORTS)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_PORTS-1:0] req_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic                 gnt_valid_o,
    output logic [ID_W-1:0]      gnt_id_o
);

    // Counter only needs to reach MAX_HOLD; one dummy bit when the hold is unlimited.
    localparam int unsigned HC_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

    typedef enum logic {StIdle, StGrant} state_t;

    state_t                r_state;
    logic [ID_W-1:0]       r_ptr;
    logic [HC_W-1:0]       r_hold_cnt;
    logic [NUM_PORTS-1:0]  r_gnt;
    logic                  r_gnt_valid;
    logic [ID_W-1:0]       r_gnt_id;

    logic                  w_owner_req;
    logic                  w_hold_expired;
    logic                  w_tenure_end;
    logic [ID_W-1:0]       w_ptr_next;
    logic [ID_W-1:0]       w_search_ptr;
    logic                  w_any;
    logic [ID_W-1:0]       w_win;
    logic [NUM_PORTS-1:0]  w_onehot;

    // Tenure end detection and the pointer the next search starts from.
    always_comb begin
        w_owner_req    = req_i[r_gnt_id];
        w_hold_expired = (MAX_HOLD != 0) && (r_hold_cnt == HC_W'(MAX_HOLD));
        w_tenure_end   = (r_state == StGrant) && (!w_owner_req || w_hold_expired);
        w_ptr_next     = r_ptr;
        if (w_tenure_end) begin
            if (RR_MODE != 0) begin
                // Owner moves to the back of the queue, so it wins only if alone.
                w_ptr_next = (r_gnt_id == ID_W'(NUM_PORTS - 1)) ? '0 : r_gnt_id + ID_W'(1);
            end else begin
                w_ptr_next = '0;
            end
        end
        w_search_ptr = (r_state == StGrant) ? w_ptr_next : r_ptr;
    end

    // Circular search starting at w_search_ptr; first asserted request wins.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (!w_any && req_i[(32'(w_search_ptr) + i) % NUM_PORTS]) begin
                w_any = 1'b1;
                w_win = ID_W'((32'(w_search_ptr) + i) % NUM_PORTS);
            end
        end
    end

    // One-hot decode of the search winner.
    always_comb begin
        w_onehot        = '0;
        w_onehot[w_win] = 1'b1;
    end

    // Arbitration FSM with registered grant outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= StIdle;
            r_ptr       <= '0;
            r_hold_cnt  <= '0;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_id    <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_any) begin
                        r_state     <= StGrant;
                        r_gnt       <= w_onehot;
                        r_gnt_valid <= 1'b1;
                        r_gnt_id    <= w_win;
                        r_hold_cnt  <= HC_W'(1);
                    end else begin
                        r_gnt       <= '0;
                        r_gnt_valid <= 1'b0;
                    end
                end
                StGrant: begin
                    if (!w_tenure_end) begin
                        // Unlimited hold leaves the counter parked instead of wrapping.
                        if (MAX_HOLD != 0) begin
                            r_hold_cnt <= r_hold_cnt + HC_W'(1);
                        end
                    end else begin
                        r_ptr <= w_ptr_next;
                        if (w_any) begin
                            r_gnt       <= w_onehot;
                            r_gnt_valid <= 1'b1;
                            r_gnt_id    <= w_win;
                            r_hold_cnt  <= HC_W'(1);
                        end else begin
                            // gnt_id_o keeps the last owner while idle.
                            r_state     <= StIdle;
                            r_gnt       <= '0;
                            r_gnt_valid <= 1'b0;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign gnt_o       = r_gnt;
    assign gnt_valid_o = r_gnt_valid;
    assign gnt_id_o    = r_gnt_id;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: a round-robin instance and a fixed-priority instance, both
// NUM_PORTS=4, MAX_HOLD=4, checked against a queue-order reference model.
module tb_rr_arbiter;

    localparam int NP   = 4;
    localparam int HOLD = 4;

    logic          clk;
    logic          rst_n;
    logic [NP-1:0] req, req_fx;
    logic [NP-1:0] gnt, gnt_fx;
    logic          valid, valid_fx;
    logic [1:0]    id, id_fx;

    int n_checks = 0;
    int n_pass   = 0;

    rr_arbiter #(.NUM_PORTS(NP), .MAX_HOLD(HOLD), .RR_MODE(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req),
        .gnt_o(gnt), .gnt_valid_o(valid), .gnt_id_o(id)
    );

    rr_arbiter #(.NUM_PORTS(NP), .MAX_HOLD(HOLD), .RR_MODE(0)) dut_fx (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_fx),
        .gnt_o(gnt_fx), .gnt_valid_o(valid_fx), .gnt_id_o(id_fx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who owns the resource, for how long, where the search starts.
    typedef struct {
        int owner;  // -1 when idle
        int ptr;
        int cnt;
        int last;   // last granted port
    } mdl_t;

    mdl_t m, mf;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.owner = -1; r.ptr = 0; r.cnt = 0; r.last = 0;
        return r;
    endfunction

    function automatic int search(int start, logic [NP-1:0] r);
        for (int i = 0; i < NP; i++) begin
            if (r[(start + i) % NP]) return (start + i) % NP;
        end
        return -1;
    endfunction

    function automatic mdl_t mdl_next(mdl_t c, logic [NP-1:0] r, bit rr);
        mdl_t n = c;
        int w;
        if (c.owner < 0) begin
            w = search(c.ptr, r);
            if (w >= 0) begin n.owner = w; n.cnt = 1; n.last = w; end
        end else if (r[c.owner] && c.cnt < HOLD) begin
            n.cnt = c.cnt + 1;
        end else begin
            if (rr) n.ptr = (c.owner + 1) % NP;
            w = search(n.ptr, r);
            if (w >= 0) begin n.owner = w; n.cnt = 1; n.last = w; end
            else n.owner = -1;
        end
        return n;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cmp(string name, logic [NP-1:0] g, logic v, logic [1:0] i, mdl_t c);
        logic [NP-1:0] eg;
        eg = (c.owner >= 0) ? NP'(1 << c.owner) : '0;
        chk({name, "_gnt"}, 32'(g), 32'(eg));
        chk({name, "_valid"}, 32'(v), 32'(c.owner >= 0));
        chk({name, "_id"}, 32'(i), 32'(c.last));
    endtask

    // Advance one clock, update both models with the sampled requests, compare.
    task automatic step(string name);
        @(posedge clk);
        #1;
        m  = mdl_next(m, req, 1'b1);
        mf = mdl_next(mf, req_fx, 1'b0);
        cmp(name, gnt, valid, id, m);
        cmp({name, "_fx"}, gnt_fx, valid_fx, id_fx, mf);
    endtask

    typedef struct {
        logic [NP-1:0] req;
        logic [NP-1:0] gnt;
    } vec_t;

    vec_t vec [17];

    initial begin
        // Rotation table: each port holds 4 cycles in order, then back to port 0.
        for (int i = 0; i < 16; i++) vec[i] = '{4'b1111, 4'(4'b0001 << (i / 4))};
        vec[16] = '{4'b1111, 4'b0001};

        m  = mdl_reset();
        mf = mdl_reset();

        // Reset with all requests asserted.
        rst_n  = 1'b0;
        req    = 4'b1111;
        req_fx = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_id", 32'(id), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Rotation through all ports.
        for (int i = 0; i < 17; i++) begin
            req = vec[i].req;
            step("rot");
            chk("rot_tbl", 32'(gnt), 32'(vec[i].gnt));
        end

        // Early release: port 2 drops after 2 cycles, port 3 takes over with no gap.
        req = 4'b0100;
        step("early_a");
        chk("early_p2", 32'(gnt), 32'(4'b0100));
        step("early_b");
        req = 4'b1001;
        step("early_c");
        chk("early_p3", 32'(gnt), 32'(4'b1000));
        chk("early_id3", 32'(id), 3);

        // Sole requester at hold limit keeps the grant, counter reloads every 4 cycles.
        req = 4'b0010;
        for (int k = 0; k < 12; k++) begin
            step("sole");
            chk("sole_gnt", 32'(gnt), 32'(4'b0010));
            chk("sole_cnt", 32'(dut.r_hold_cnt), 32'((k % 4) + 1));
        end

        // Fixed priority: port 1 first, then port 0 whenever it requests.
        req_fx = 4'b1110;
        step("fx_a");
        chk("fx_p1", 32'(gnt_fx), 32'(4'b0010));
        req_fx = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            step("fx_b");
            chk("fx_p1_hold", 32'(gnt_fx), 32'(4'b0010));
        end
        for (int k = 0; k < 8; k++) begin
            step("fx_c");
            chk("fx_p0", 32'(gnt_fx), 32'(4'b0001));
        end
        req_fx = 4'b0000;

        // Async reset mid-tenure while port 2 holds the grant.
        req = 4'b0100;
        step("ar_a");
        chk("ar_pre", 32'(gnt), 32'(4'b0100));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_gnt", 32'(gnt), 0);
        chk("ar_valid", 32'(valid), 0);
        chk("ar_id", 32'(id), 0);
        m  = mdl_reset();
        mf = mdl_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("ar_ptr", 32'(dut.r_ptr), 0);
        step("ar_b");
        chk("ar_post", 32'(gnt), 32'(4'b0100));

        // Random requests, changed occasionally so tenures can reach the hold limit.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(3) == 0) req = NP'($urandom);
            if ($urandom_range(3) == 0) req_fx = NP'($urandom);
            step("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
